mac_tx_frame_gen: RTL and testbench
===================================

Name: mac_tx_frame_gen

Overview:
- Frame assembler directly upstream of Mac_TX; generates the complete per-byte stream that Mac_TX serialises onto RGMII.
- Stream is: preamble/SFD, destination MAC, source MAC, 802.3 length field, payload drawn from a first-word-fall-through (FWFT) payload FIFO, then zero padding up to the 46-byte minimum.
- FCS is appended by Mac_TX and is not produced here.
- Drives Mac_TX's Trig_i, Data_in and Last_byte; consumes its Data_Strobe and Busy.

Parameters:
DST_MAC, 48'h4B45_5900_0001, destination address, sent MSB byte first
SRC_MAC, 48'h3C97_0E38_46F0, source address, sent MSB byte first
MAX_LEN, 1500, largest accepted payload length in bytes
MIN_PLD, 46, minimum payload field length; shorter payloads are zero-padded

Ports:
clk  in  1  system clock (125 MHz GTX domain)
Reset_n_i  in  1  asynchronous, active-low reset
Start_i  in  1  frame request, sampled only while Ready_o=1
Len_i  in  11  payload byte count, latched on accepted Start_i
Ready_o  out  1  idle and able to accept Start_i
Err_o  out  1  one-cycle pulse when Start_i is rejected (Len_i=0 or Len_i>MAX_LEN)
Underrun_o  out  1  sticky flag: FIFO was empty when a payload byte was needed; cleared by the next accepted Start_i
Pld_Data_i  in  8  FWFT FIFO head byte
Pld_Empty_i  in  1  FIFO empty
Pld_Rd_o  out  1  FIFO pop, one per consumed payload byte
Trig_o  out  1  to Mac_TX Trig_i
Data_o  out  8  to Mac_TX Data_in
Last_byte_o  out  1  to Mac_TX Last_byte
Data_Strobe_i  in  1  from Mac_TX: current Data_o byte consumed this edge
Busy_i  in  1  from Mac_TX Busy

Behaviour:
- Reset (async assert, sync release): state IDLE. Ready_o=1. Trig_o, Err_o, Underrun_o, Pld_Rd_o and Last_byte_o are all 0. Data_o=8'h00. Byte index=0.
- States: IDLE -> SEND -> DRAIN -> IDLE.
- IDLE, on Start_i=1:
  - If Len_i is 1..MAX_LEN: latch L=Len_i; compute T = 22 + max(L, MIN_PLD) (12-bit); index=0; Data_o=8'h55; Trig_o=1 for exactly one cycle; Ready_o=0; clear Underrun_o; go to SEND.
  - Otherwise: Err_o=1 for one cycle; remain in IDLE.
- SEND: Data_o holds the byte for the current index i. The value for each range of i is:
  - i=0..6: 8'h55.
  - i=7: 8'hD5.
  - i=8..13: DST_MAC bytes, MSB first.
  - i=14..19: SRC_MAC bytes, MSB first.
  - i=20: L[10:8] zero-extended to 8 bits.
  - i=21: L[7:0].
  - i=22..21+L: payload byte.
  - i=22+L..T-1: 8'h00.
- Advancing in SEND: when Data_Strobe_i=1 and i<T-1, the next edge sets i=i+1 and registers the new Data_o. Data_o is stable between strobes.
- Payload fetch: the registered payload byte is Pld_Data_i, and Pld_Rd_o=1 in that same cycle (combinational with the advance). Consequently the FIFO is popped exactly L times per frame.
- Underrun: if Pld_Empty_i=1 when a payload byte is needed, the byte is 8'h00, there is no pop, Underrun_o is set, and the frame still completes with length T.
- Last_byte_o = (state==SEND && i==T-1). A strobe on the last byte moves the block to DRAIN; Last_byte_o then drops the next cycle and Data_o returns to 8'h00.
- DRAIN: wait for Busy_i=0 (the FCS is being sent by Mac_TX), then go to IDLE with Ready_o=1 on the following cycle.
- Start_i is ignored outside IDLE (no Err_o). Data_Strobe_i is ignored outside SEND.
- Reset asserted mid-frame: immediate return to reset values. FIFO contents are left untouched.
- Simultaneous Start_i and Busy_i=1 in IDLE: Start_i is accepted anyway. Mac_TX arbitrates via Trig_i.

Test Plan:
- Reset, then Start_i with Len_i=12 and a FIFO of 12 bytes 0x01..0x0C; strobe every cycle after Trig_o. Required:
  - Trig_o pulses once.
  - 68 bytes are emitted: 55×7, D5, 4B 45 59 00 00 01, 3C 97 0E 38 46 F0, 00 0C, 01..0C, then 34×00.
  - Last_byte_o is high only on byte 68.
  - Pld_Rd_o is high for exactly 12 cycles.
- Len_i=100 with strobes every 2nd cycle -> 122 bytes; length field 00 64; 100 pops; Data_o held between strobes; Ready_o returns only after Busy_i falls.
- Len_i=0 and then Len_i=1501 -> Err_o pulses once each, no Trig_o, Ready_o stays 1.
- Len_i=20 with FIFO holding 15 bytes -> bytes 15..19 of the payload are 00, Underrun_o=1, only 15 pops, frame still 68 bytes. A following valid Start_i clears Underrun_o.
- Start_i pulsed during SEND -> no effect; byte sequence is unchanged.
- Reset_n_i asserted at byte 30 of a Len_i=64 frame -> all outputs take reset values asynchronously. A new Start_i after release produces a full, correct frame.

Source files
------------

// File: rtl/mac_tx_frame_gen_if.sv
// Byte-stream link between the frame generator, its payload FIFO and Mac_TX.
// master = frame generator side, slave = FIFO / Mac_TX side.
interface mac_tx_frame_gen_if;
   logic [7:0] Pld_Data_i;
   logic       Pld_Empty_i;
   logic       Pld_Rd_o;
   logic       Trig_o;
   logic [7:0] Data_o;
   logic       Last_byte_o;
   logic       Data_Strobe_i;
   logic       Busy_i;

   modport master (
      input  Pld_Data_i, Pld_Empty_i, Data_Strobe_i, Busy_i,
      output Pld_Rd_o, Trig_o, Data_o, Last_byte_o
   );

   modport slave (
      output Pld_Data_i, Pld_Empty_i, Data_Strobe_i, Busy_i,
      input  Pld_Rd_o, Trig_o, Data_o, Last_byte_o
   );
endinterface

// File: rtl/mac_tx_frame_gen.sv
// Ethernet frame assembler feeding Mac_TX: preamble/SFD, addresses, length,
// FIFO payload and zero padding; the FCS is appended downstream.
module mac_tx_frame_gen #(
   parameter logic [47:0] DST_MAC = 48'h4B45_5900_0001,
   parameter logic [47:0] SRC_MAC = 48'h3C97_0E38_46F0,
   parameter int          MAX_LEN = 1500,
   parameter int          MIN_PLD = 46
) (
   input  logic                 clk,
   input  logic                 Reset_n_i,
   input  logic                 Start_i,
   input  logic [10:0]          Len_i,
   output logic                 Ready_o,
   output logic                 Err_o,
   output logic                 Underrun_o,
   mac_tx_frame_gen_if.master   tx
);

   localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
   localparam logic [11:0] MIN_T   = 12'(MIN_PLD);
   localparam logic [11:0] HDR_LEN = 12'd22;

   typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

   state_t      state;
   logic [11:0] idx;
   logic [11:0] total;
   logic [10:0] len;
   logic [7:0]  data_q;
   logic        trig_q;
   logic        err_q;
   logic        underrun_q;
   logic        ready_q;
   logic        last_q;

   logic [11:0] nxt_idx;
   logic        in_pld;
   logic        advance;
   logic        pld_rd;
   logic        pld_hole;

   // Non-payload byte for index i (header bytes; padding and beyond read as zero)
   function automatic logic [7:0] hdr_byte(input logic [11:0] i, input logic [10:0] l);
      logic [7:0] b;
      int         k;
      b = 8'h00;
      k = int'(i);
      if (i <= 12'd6)       b = 8'h55;
      else if (i == 12'd7)  b = 8'hD5;
      else if (i <= 12'd13) b = 8'(DST_MAC >> (8 * (13 - k)));
      else if (i <= 12'd19) b = 8'(SRC_MAC >> (8 * (19 - k)));
      else if (i == 12'd20) b = {5'd0, l[10:8]};
      else if (i == 12'd21) b = l[7:0];
      return b;
   endfunction

   always_comb begin
      nxt_idx  = idx + 12'd1;
      in_pld   = (nxt_idx >= HDR_LEN) && (nxt_idx < HDR_LEN + {1'b0, len});
      advance  = (state == SEND) && tx.Data_Strobe_i && !last_q;
      pld_rd   = advance && in_pld && !tx.Pld_Empty_i;
      pld_hole = advance && in_pld && tx.Pld_Empty_i;
   end

   always_ff @(posedge clk or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         state      <= IDLE;
         idx        <= 12'd0;
         total      <= 12'd0;
         len        <= 11'd0;
         data_q     <= 8'h00;
         trig_q     <= 1'b0;
         err_q      <= 1'b0;
         underrun_q <= 1'b0;
         ready_q    <= 1'b1;
         last_q     <= 1'b0;
      end else begin
         trig_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (Start_i) begin
                  if ((Len_i != 11'd0) && (Len_i <= MAX_L)) begin
                     len        <= Len_i;
                     total      <= HDR_LEN + (({1'b0, Len_i} < MIN_T) ? MIN_T : {1'b0, Len_i});
                     idx        <= 12'd0;
                     data_q     <= 8'h55;
                     trig_q     <= 1'b1;
                     ready_q    <= 1'b0;
                     underrun_q <= 1'b0;
                     last_q     <= 1'b0;
                     state      <= SEND;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            SEND: begin
               if (advance) begin
                  idx    <= nxt_idx;
                  last_q <= (nxt_idx == total - 12'd1);
                  if (in_pld)
                     data_q <= tx.Pld_Empty_i ? 8'h00 : tx.Pld_Data_i;
                  else
                     data_q <= hdr_byte(nxt_idx, len);
                  if (pld_hole)
                     underrun_q <= 1'b1;
               end else if (tx.Data_Strobe_i) begin
                  // Strobe on the last byte: hand over to Mac_TX for the FCS
                  last_q <= 1'b0;
                  data_q <= 8'h00;
                  state  <= DRAIN;
               end
            end
            DRAIN: begin
               if (!tx.Busy_i) begin
                  idx     <= 12'd0;
                  ready_q <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign Ready_o        = ready_q;
   assign Err_o          = err_q;
   assign Underrun_o     = underrun_q;
   assign tx.Pld_Rd_o    = pld_rd;
   assign tx.Trig_o      = trig_q;
   assign tx.Data_o      = data_q;
   assign tx.Last_byte_o = last_q;

endmodule

// File: tb/tb_mac_tx_frame_gen.sv
// Testbench for mac_tx_frame_gen: FIFO and Mac_TX models plus a byte-list
// reference model of the frame built from the frame layout rules.
module tb_mac_tx_frame_gen;

   localparam logic [47:0] DST = 48'h4B45_5900_0001;
   localparam logic [47:0] SRC = 48'h3C97_0E38_46F0;

   logic        clk = 1'b0;
   logic        Reset_n_i;
   logic        Start_i;
   logic [10:0] Len_i;
   logic        Ready_o;
   logic        Err_o;
   logic        Underrun_o;

   always #4 clk = ~clk;

   mac_tx_frame_gen_if tx();

   mac_tx_frame_gen dut (
      .clk        (clk),
      .Reset_n_i  (Reset_n_i),
      .Start_i    (Start_i),
      .Len_i      (Len_i),
      .Ready_o    (Ready_o),
      .Err_o      (Err_o),
      .Underrun_o (Underrun_o),
      .tx         (tx)
   );

   // FWFT FIFO model: never reset, a DUT reset leaves its contents alone
   logic [7:0] fifo_mem [0:4095];
   int         wr_cnt = 0;
   int         rd_ptr = 0;

   assign tx.Pld_Empty_i = (rd_ptr >= wr_cnt);
   assign tx.Pld_Data_i  = fifo_mem[rd_ptr[11:0]];

   always @(posedge clk)
      if (tx.Pld_Rd_o) rd_ptr <= rd_ptr + 1;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_b [0:2047];
   int         exp_t;

   task automatic load_fifo(input int cnt, input bit rnd);
      for (int k = 0; k < cnt; k++) begin
         fifo_mem[wr_cnt[11:0]] = rnd ? 8'($urandom_range(1, 255)) : 8'(k + 1);
         wr_cnt++;
      end
   endtask

   // Reference frame: list of bytes the generator should hand to Mac_TX
   task automatic build_model(input int L);
      int avail;
      int pld;
      avail = wr_cnt - rd_ptr;
      pld   = (L < 46) ? 46 : L;
      exp_t = 22 + pld;
      for (int k = 0; k < 7; k++) exp_b[k] = 8'h55;
      exp_b[7] = 8'hD5;
      for (int k = 0; k < 6; k++) begin
         exp_b[8 + k]  = 8'(DST >> (40 - 8 * k));
         exp_b[14 + k] = 8'(SRC >> (40 - 8 * k));
      end
      exp_b[20] = 8'(L >> 8);
      exp_b[21] = 8'(L);
      for (int k = 0; k < pld; k++)
         exp_b[22 + k] = (k < L && k < avail) ? fifo_mem[12'(rd_ptr + k)] : 8'h00;
   endtask

   task automatic run_frame(input int L, input int stride, input int poke_at,
                            input int abort_at, input bit busy_start);
      int n, c, pops, trigs, errs, avail, exp_pops;
      bit strobe;
      avail    = wr_cnt - rd_ptr;
      exp_pops = (L < avail) ? L : avail;
      build_model(L);
      @(negedge clk);
      Start_i = 1'b1; Len_i = 11'(L); tx.Busy_i = busy_start;
      @(negedge clk);
      Start_i = 1'b0; tx.Busy_i = 1'b1;
      n_tests++; if (tx.Trig_o !== 1'b1) begin n_fail++; $display("FAIL trig L=%0d: got %b want 1", L, tx.Trig_o); end
      n_tests++; if (Ready_o !== 1'b0) begin n_fail++; $display("FAIL ready_busy L=%0d: got %b want 0", L, Ready_o); end
      n_tests++; if (Underrun_o !== 1'b0) begin n_fail++; $display("FAIL underrun_clear L=%0d: got %b want 0", L, Underrun_o); end
      trigs = 1; pops = 0; errs = 0; n = 0; c = 0;
      while (n < exp_t && c < 5000) begin
         @(negedge clk);
         if (Err_o === 1'b1) errs++;
         if (tx.Trig_o === 1'b1) trigs++;
         if (abort_at >= 0 && n == abort_at) begin
            Reset_n_i = 1'b0;
            #1;
            n_tests++; if ({Ready_o, Err_o, Underrun_o, tx.Trig_o, tx.Last_byte_o, tx.Pld_Rd_o} !== 6'b100000)
               begin n_fail++; $display("FAIL async_reset_ctrl: got %b want 100000", {Ready_o, Err_o, Underrun_o, tx.Trig_o, tx.Last_byte_o, tx.Pld_Rd_o}); end
            n_tests++; if (tx.Data_o !== 8'h00) begin n_fail++; $display("FAIL async_reset_data: got %h want 00", tx.Data_o); end
            tx.Data_Strobe_i = 1'b0; tx.Busy_i = 1'b0;
            @(negedge clk);
            Reset_n_i = 1'b1;
            @(negedge clk);
            return;
         end
         n_tests++; if (tx.Data_o !== exp_b[n]) begin n_fail++; $display("FAIL data L=%0d byte %0d: got %h want %h", L, n, tx.Data_o, exp_b[n]); end
         n_tests++; if (tx.Last_byte_o !== (n == exp_t - 1)) begin n_fail++; $display("FAIL last L=%0d byte %0d: got %b want %b", L, n, tx.Last_byte_o, (n == exp_t - 1)); end
         Start_i = (c == poke_at);
         Len_i   = (c == poke_at) ? 11'd0 : 11'(L);
         strobe  = ((c % stride) == 0);
         tx.Data_Strobe_i = strobe;
         #1;
         if (tx.Pld_Rd_o === 1'b1) pops++;
         if (strobe) n++;
         c++;
      end
      @(negedge clk);
      tx.Data_Strobe_i = 1'b0; Start_i = 1'b0;
      n_tests++; if (n !== exp_t) begin n_fail++; $display("FAIL frame_timeout L=%0d: got %0d bytes want %0d", L, n, exp_t); end
      n_tests++; if ({tx.Last_byte_o, tx.Data_o} !== 9'h000) begin n_fail++; $display("FAIL drain_out L=%0d: got last=%b data=%h want 0/00", L, tx.Last_byte_o, tx.Data_o); end
      repeat (3) @(negedge clk);
      n_tests++; if (Ready_o !== 1'b0) begin n_fail++; $display("FAIL drain_ready L=%0d: got %b want 0", L, Ready_o); end
      tx.Busy_i = 1'b0;
      @(negedge clk);
      n_tests++; if (Ready_o !== 1'b1) begin n_fail++; $display("FAIL ready_return L=%0d: got %b want 1", L, Ready_o); end
      n_tests++; if (pops !== exp_pops) begin n_fail++; $display("FAIL pops L=%0d: got %0d want %0d", L, pops, exp_pops); end
      n_tests++; if (trigs !== 1) begin n_fail++; $display("FAIL trig_count L=%0d: got %0d want 1", L, trigs); end
      n_tests++; if (errs !== 0) begin n_fail++; $display("FAIL err_in_frame L=%0d: got %0d want 0", L, errs); end
      n_tests++; if (Underrun_o !== (avail < L)) begin n_fail++; $display("FAIL underrun L=%0d: got %b want %b", L, Underrun_o, (avail < L)); end
   endtask

   task automatic test_reset();
      Reset_n_i = 1'b0; Start_i = 1'b0; Len_i = 11'd0;
      tx.Data_Strobe_i = 1'b0; tx.Busy_i = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++; if ({Ready_o, Err_o, Underrun_o, tx.Trig_o, tx.Last_byte_o, tx.Pld_Rd_o} !== 6'b100000)
         begin n_fail++; $display("FAIL reset_ctrl: got %b want 100000", {Ready_o, Err_o, Underrun_o, tx.Trig_o, tx.Last_byte_o, tx.Pld_Rd_o}); end
      n_tests++; if (tx.Data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", tx.Data_o); end
      Reset_n_i = 1'b1;
      @(negedge clk);
      n_tests++; if (Ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", Ready_o); end
   endtask

   task automatic test_basic();
      load_fifo(12, 1'b0);
      run_frame(12, 1, -1, -1, 1'b0);
   endtask

   task automatic test_slow_strobe();
      load_fifo(100, 1'b1);
      run_frame(100, 2, -1, -1, 1'b0);
   endtask

   task automatic test_len_err();
      int bad [2];
      bad[0] = 0; bad[1] = 1501;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         Start_i = 1'b1; Len_i = 11'(bad[k]);
         @(negedge clk);
         Start_i = 1'b0;
         n_tests++; if (Err_o !== 1'b1) begin n_fail++; $display("FAIL err_pulse len=%0d: got %b want 1", bad[k], Err_o); end
         n_tests++; if ({tx.Trig_o, Ready_o} !== 2'b01) begin n_fail++; $display("FAIL err_trig_ready len=%0d: got %b want 01", bad[k], {tx.Trig_o, Ready_o}); end
         @(negedge clk);
         n_tests++; if ({Err_o, tx.Trig_o, Ready_o} !== 3'b001) begin n_fail++; $display("FAIL err_one_cycle len=%0d: got %b want 001", bad[k], {Err_o, tx.Trig_o, Ready_o}); end
      end
   endtask

   task automatic test_underrun();
      load_fifo(15, 1'b0);
      run_frame(20, 1, -1, -1, 1'b0);
      @(negedge clk);
      n_tests++; if (Underrun_o !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky: got %b want 1", Underrun_o); end
      load_fifo(10, 1'b1);
      run_frame(10, 1, -1, -1, 1'b0);
   endtask

   task automatic test_start_in_send();
      load_fifo(30, 1'b1);
      run_frame(30, 1, 10, -1, 1'b1);
   endtask

   task automatic test_reset_mid();
      load_fifo(64, 1'b0);
      run_frame(64, 1, -1, 30, 1'b0);
      load_fifo(64, 1'b1);
      run_frame(64, 1, -1, -1, 1'b0);
   endtask

   task automatic test_random();
      int L;
      for (int r = 0; r < 4; r++) begin
         L = $urandom_range(1, 120);
         load_fifo(($urandom_range(0, 1) == 1) ? L : $urandom_range(0, L), 1'b1);
         run_frame(L, $urandom_range(1, 3), -1, -1, 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_slow_strobe();
      test_len_err();
      test_underrun();
      test_start_in_send();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
